// File: rtl/keycode_move_ctrl.sv
// Turns the USB keycode register into queued movement events (new press + frame-paced repeat).
// Auto-repeat is built only when KEYCODE_REPEAT_EN is defined; otherwise one event per press.
module keycode_move_ctrl #(
    parameter int REPEAT_DELAY  = 24,
    parameter int REPEAT_PERIOD = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_player,
    output logic [1:0] evt_dir,
    output logic       held,
    output logic       overflow,
    output logic [1:0] o_dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } state_t;

    logic [7:0] r_key_q;
    logic       r_last_valid;
    logic [2:0] r_last_code;
    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_key_valid;
    logic [2:0] w_key_code;
    logic       w_new_key;
    logic       w_push;

    // Event code is {player, dir}; unmapped codes are treated exactly like "no key".
    always_comb begin
        w_key_valid = 1'b1;
        w_key_code  = 3'b000;
        case (r_key_q)
            8'h1A:   w_key_code = 3'b000;
            8'h16:   w_key_code = 3'b001;
            8'h04:   w_key_code = 3'b010;
            8'h07:   w_key_code = 3'b011;
            8'h52:   w_key_code = 3'b100;
            8'h51:   w_key_code = 3'b101;
            8'h50:   w_key_code = 3'b110;
            8'h4F:   w_key_code = 3'b111;
            default: w_key_valid = 1'b0;
        endcase
    end

    assign w_new_key = w_key_valid && (!r_last_valid || (r_last_code != w_key_code));

`ifdef KEYCODE_REPEAT_EN
    localparam int MAXV  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W = $clog2(MAXV + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // A changed key outranks a frame tick in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        if (!w_key_valid) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (w_new_key) begin
            w_push      = 1'b1;
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
        end else if (frame_tick) begin
            case (r_state)
                PRESSED: begin
                    if (r_cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                        w_push      = 1'b1;
                        w_state_nxt = REPEAT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (r_cnt == CNT_W'(REPEAT_PERIOD - 1)) begin
                        w_push    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: w_cnt_nxt = r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= w_cnt_nxt;
    end
`else
    logic w_unused_tick;
    assign w_unused_tick = frame_tick;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        if (!w_key_valid) begin
            w_state_nxt = IDLE;
        end else if (w_new_key) begin
            w_push      = 1'b1;
            w_state_nxt = PRESSED;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_q      <= 8'h00;
            r_last_valid <= 1'b0;
            r_last_code  <= 3'b000;
            r_state      <= IDLE;
        end else begin
            r_key_q      <= keycode;
            r_last_valid <= w_key_valid;
            r_last_code  <= w_key_code;
            r_state      <= w_state_nxt;
        end
    end

    assign held        = (r_state != IDLE);
    assign o_dbg_state = r_state;

    // Event queue, first-word fall-through. Handshake: the head transfers on a cycle where
    // evt_valid && evt_ready; evt_ready while empty has no effect.
    logic [2:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [2:0]    r_hold;
    logic          r_overflow;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic [2:0]    w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = !w_empty && evt_ready;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_key_code;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hold     <= 3'b000;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
            if (!w_empty) r_hold <= r_mem[r_rd_ptr];
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // While empty the outputs keep showing the last head that was presented.
    assign w_head     = w_empty ? r_hold : r_mem[r_rd_ptr];
    assign evt_valid  = !w_empty;
    assign evt_player = w_head[2];
    assign evt_dir    = w_head[1:0];
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_keycode_move_ctrl.sv
// Directed bench for keycode_move_ctrl; repeat checks follow KEYCODE_REPEAT_EN.
module tb_keycode_move_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] keycode;
    logic       frame_tick;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_player;
    logic [1:0] evt_dir;
    logic       held;
    logic       overflow;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_evt    = 0;
    int base;
    logic [2:0] exp_q[$];

    keycode_move_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .keycode     (keycode),
        .frame_tick  (frame_tick),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_player  (evt_player),
        .evt_dir     (evt_dir),
        .held        (held),
        .overflow    (overflow),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            tick(1);
            frame_tick = 1'b0;
            tick(3);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Scoreboard: every accepted event must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            n_evt++;
            if (exp_q.size() == 0) check("evt_unexpected", 32'(exp_q.size()), 1);
            else check("evt_data", {evt_player, evt_dir}, exp_q.pop_front());
        end
    end

    initial begin
        keycode    = 8'h00;
        frame_tick = 1'b0;
        evt_ready  = 1'b0;
        do_reset();
        check("rst_valid", evt_valid, 0);
        check("rst_player", evt_player, 0);
        check("rst_dir", evt_dir, 0);
        check("rst_held", held, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", dbg_state, 0);

        // Single short press: evt_valid two edges after the change, one cycle wide.
        evt_ready = 1'b1;
        base = n_evt;
        keycode = 8'h1A;
        exp_q.push_back(3'b000);
        tick(1);
        check("t1_lat1_valid", evt_valid, 0);
        tick(1);
        check("t1_lat2_valid", evt_valid, 1);
        check("t1_player", evt_player, 0);
        check("t1_dir", evt_dir, 0);
        check("t1_held", held, 1);
        tick(1);
        check("t1_pulse_end", evt_valid, 0);
        keycode = 8'h00;
        tick(5);
        check("t1_evt_count", n_evt - base, 1);
        check("t1_released", held, 0);

        // Long hold of P1 right.
        base = n_evt;
        keycode = 8'h4F;
`ifdef KEYCODE_REPEAT_EN
        repeat (3) exp_q.push_back(3'b111);
        tick(3);
        frames(39);
`else
        exp_q.push_back(3'b111);
        tick(3);
        frames(100);
`endif
        keycode = 8'h00;
        tick(5);
`ifdef KEYCODE_REPEAT_EN
        check("t2_evt_count", n_evt - base, 3);
`else
        check("t2_evt_count", n_evt - base, 1);
`endif
        check("t2_overflow", overflow, 0);

        // Overflow: six alternating presses with the consumer stalled.
        evt_ready = 1'b0;
        base = n_evt;
        for (int i = 0; i < 6; i++) begin
            keycode = i[0] ? 8'h07 : 8'h04;
            tick(1);
        end
        keycode = 8'h00;
        repeat (2) begin
            exp_q.push_back(3'b010);
            exp_q.push_back(3'b011);
        end
        tick(3);
        check("t3_overflow", overflow, 1);
        check("t3_valid", evt_valid, 1);
        check("t3_head_dir", evt_dir, 2);
        check("t3_held", held, 0);
        evt_ready = 1'b1;
        tick(6);
        check("t3_drain_count", n_evt - base, 4);
        check("t3_empty", evt_valid, 0);
        check("t3_hold_dir", evt_dir, 3);
        check("t3_overflow_sticky", overflow, 1);
        evt_ready = 1'b0;

        // Full queue, push and pop in the same cycle.
        do_reset();
        check("t4_rst_overflow", overflow, 0);
        check("t4_rst_dir", evt_dir, 0);
        base = n_evt;
        keycode = 8'h1A; tick(1);
        keycode = 8'h16; tick(1);
        keycode = 8'h04; tick(1);
        keycode = 8'h07; tick(1);
        keycode = 8'h00;
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b100);
        tick(3);
        check("t4_full_valid", evt_valid, 1);
        check("t4_full_head", evt_dir, 0);
        keycode = 8'h52;
        tick(1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        keycode = 8'h00;
        check("t4_overflow", overflow, 0);
        check("t4_valid", evt_valid, 1);
        check("t4_new_head_dir", evt_dir, 1);
        check("t4_new_head_player", evt_player, 0);
        tick(2);
        evt_ready = 1'b1;
        tick(6);
        check("t4_drain_count", n_evt - base, 5);
        check("t4_empty", evt_valid, 0);
        check("t4_hold_player", evt_player, 1);

        // Key change coinciding with a frame tick restarts the counter.
        base = n_evt;
        keycode = 8'h52;
        exp_q.push_back(3'b100);
        tick(3);
        frames(5);
        keycode = 8'h51;
        exp_q.push_back(3'b101);
        tick(1);
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        tick(2);
        check("t5_change_count", n_evt - base, 2);
`ifdef KEYCODE_REPEAT_EN
        frames(23);
        check("t5_no_early_repeat", n_evt - base, 2);
        exp_q.push_back(3'b101);
        frames(1);
        check("t5_repeat_count", n_evt - base, 3);
        check("t5_state", dbg_state, 2);
`else
        frames(24);
        check("t5_repeat_count", n_evt - base, 2);
        check("t5_state", dbg_state, 1);
`endif
        keycode = 8'h99;
        tick(4);
        check("t5_unmapped_held", held, 0);
        check("t5_unmapped_valid", evt_valid, 0);
`ifdef KEYCODE_REPEAT_EN
        check("t5_unmapped_count", n_evt - base, 3);
`else
        check("t5_unmapped_count", n_evt - base, 2);
`endif

        // Reset in the middle of a hold: the held key counts as a fresh press afterwards.
        base = n_evt;
        keycode = 8'h16;
        exp_q.push_back(3'b001);
        tick(4);
        check("t6_first_count", n_evt - base, 1);
        check("t6_held", held, 1);
        reset = 1'b1;
        tick(1);
        check("t6_rst_valid", evt_valid, 0);
        check("t6_rst_held", held, 0);
        check("t6_rst_dir", evt_dir, 0);
        check("t6_rst_overflow", overflow, 0);
        reset = 1'b0;
        exp_q.push_back(3'b001);
        tick(5);
        check("t6_repress_count", n_evt - base, 2);
        check("t6_held_again", held, 1);
        keycode = 8'h00;
        tick(3);
        check("end_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
